// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform generator DAC path: SPI command bytes,
// frame geometry and the transmit sequencer state encoding.
package wavegen_pkg;

    localparam int          FRAME_BITS  = 24;
    localparam logic [7:0]  CMD_WR_A    = 8'h10;
    localparam logic [7:0]  CMD_WR_B    = 8'h11;
    localparam logic [15:0] OFFSET_FLIP = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        LOAD
    } dac_state_t;

    // Signed two's-complement sample to offset binary, prefixed by the DAC command.
    function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [7:0]  cmd,
                                                        input logic [15:0] sample);
        return {cmd, sample ^ OFFSET_FLIP};
    endfunction

endpackage

// File: rtl/dac_spi_shift.sv
// SPI mode-0 serialiser: one 24-bit frame per start pulse, MSB first, sclk idles low.
// done is high in the final cycle of the frame (the cycle before the 24th falling edge).
module dac_spi_shift
    import wavegen_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  done
);

    localparam logic [31:0] HALF_LAST = 32'(CLK_DIV - 1);
    localparam logic [4:0]  BIT_LAST  = 5'(FRAME_BITS - 1);

    logic                  active;
    logic [31:0]           half_cnt;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] sreg;
    logic                  half_end;

    assign half_end = active && (half_cnt == HALF_LAST);
    assign done     = half_end && sclk && (bit_cnt == BIT_LAST);
    assign mosi     = sreg[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= data;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    // Falling edge: advance data; the last one also clears mosi.
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                        sreg   <= '0;
                    end else begin
                        sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Sample-rate driven SPI transmitter for a dual 16-bit DAC: captures ch_a/ch_b on a
// strobe, sends channel A then optionally B, then pulses ldac_n to update both outputs.
module dac_spi_tx
    import wavegen_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 500,
    parameter int CS_GAP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        dual_en,
    input  logic [15:0] ch_a,
    input  logic [15:0] ch_b,
    input  logic        overrun_clr,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        overrun
);

    localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_DIV - 1);
    localparam logic [31:0] GAP_LAST    = 32'(CS_GAP - 1);
    localparam logic [31:0] LOAD_LAST   = 32'(2 * CLK_DIV - 1);

    dac_state_t            state, state_nx;
    logic [31:0]           sample_cnt;
    logic [31:0]           tmr;
    logic                  strobe;
    logic                  chan_b, chan_b_nx;
    logic                  dual_q;
    logic [15:0]           cap_b;
    logic                  sh_start;
    logic                  sh_done;
    logic [FRAME_BITS-1:0] sh_data;

    assign strobe = enable && (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (!enable || strobe) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    // Channel A goes straight into the shifter at the strobe; only B needs holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_b  <= '0;
            dual_q <= 1'b0;
        end else if (strobe && state == IDLE) begin
            cap_b  <= ch_b;
            dual_q <= dual_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            chan_b  <= 1'b0;
            tmr     <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nx;
            chan_b <= chan_b_nx;
            tmr    <= (state_nx != state || state == IDLE) ? '0 : tmr + 32'd1;
            if (strobe && state != IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        chan_b_nx = chan_b;
        sh_start  = 1'b0;
        sh_data   = dac_frame(CMD_WR_A, ch_a);
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    state_nx  = SHIFT;
                    chan_b_nx = 1'b0;
                    sh_start  = 1'b1;
                end
            end
            SHIFT: begin
                if (sh_done) state_nx = GAP;
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    if (!chan_b && dual_q) begin
                        state_nx  = SHIFT;
                        chan_b_nx = 1'b1;
                        sh_start  = 1'b1;
                        sh_data   = dac_frame(CMD_WR_B, cap_b);
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (tmr == LOAD_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    dac_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sh_start),
        .data  (sh_data),
        .sclk  (sclk),
        .mosi  (mosi),
        .done  (sh_done)
    );

    assign cs_n   = (state != SHIFT);
    assign ldac_n = (state != LOAD);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a table of sample vectors plus hand-written sequences for
// input changes mid-frame, overrun, reset mid-frame and enable dropped mid-frame.
`timescale 1ns/1ps
module tb_dac_spi_tx;

    localparam int CLK_DIV   = 4;
    localparam int CS_GAP    = 8;
    localparam int SDIV      = 500;
    localparam int SDIV_F    = 100;
    localparam int FRAME_CYC = 48 * CLK_DIV;
    localparam int NV        = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dual_en = 1'b0;
    logic [15:0] ch_a = '0;
    logic [15:0] ch_b = '0;
    logic        overrun_clr = 1'b0;
    logic        sclk, mosi, cs_n, ldac_n, busy, overrun;

    logic        en_f = 1'b0;
    logic        clr_f = 1'b0;
    logic        f_sclk, f_mosi, f_cs_n, f_ldac_n, f_busy, f_overrun;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SDIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dual_en(dual_en),
        .ch_a(ch_a), .ch_b(ch_b), .overrun_clr(overrun_clr),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .ldac_n(ldac_n),
        .busy(busy), .overrun(overrun)
    );

    dac_spi_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SDIV_F), .CS_GAP(CS_GAP)) dut_f (
        .clk(clk), .rst_n(rst_n), .enable(en_f), .dual_en(dual_en),
        .ch_a(ch_a), .ch_b(ch_b), .overrun_clr(clr_f),
        .sclk(f_sclk), .mosi(f_mosi), .cs_n(f_cs_n), .ldac_n(f_ldac_n),
        .busy(f_busy), .overrun(f_overrun)
    );

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI monitor: reassembles frames on sclk rising edges and scores them.
    logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_ldac = 1'b1;
    logic [23:0] word = '0;
    logic [23:0] exp_w;
    int nbits = 0, low_cnt = 0, stab_bad = 0, gap_cnt = 0, last_gap = 0;
    int ldac_cnt = 0, last_ldac = 0, frames = 0, pulses = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0; low_cnt = 0; stab_bad = 0; word = '0; ldac_cnt = 0; gap_cnt = 0;
            prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; prev_ldac = 1'b1;
        end else begin
            if (!cs_n) begin
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    if (mosi !== prev_mosi) stab_bad++;
                    word = {word[22:0], mosi};
                    nbits++;
                end
            end else begin
                gap_cnt++;
            end
            if (!cs_n && prev_cs) begin
                last_gap = gap_cnt;
                gap_cnt  = 0;
            end
            if (cs_n && !prev_cs) begin
                frames++;
                check("frame_bits", nbits, 24);
                check("cs_low_cycles", low_cnt, FRAME_CYC);
                check("mosi_stable", stab_bad, 0);
                check("idle_lines", {sclk, mosi}, 2'b00);
                check("frame_queued", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("frame_word", word, exp_w);
                end
                nbits = 0; low_cnt = 0; stab_bad = 0; word = '0;
            end
            if (!ldac_n) ldac_cnt++;
            if (ldac_n && !prev_ldac) begin
                pulses++;
                last_ldac = ldac_cnt;
                ldac_cnt  = 0;
            end
            prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi; prev_ldac = ldac_n;
        end
    end

    // Raise enable with the sample counter at 0 and time the first cs_n assertion.
    task automatic kick(input string name);
        int n = 0;
        enable = 1'b1;
        while (cs_n !== 1'b0 && n < 2 * SDIV) begin
            @(negedge clk);
            n++;
        end
        check(name, n, SDIV);
    endtask

    task automatic finish_seq(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        dual;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
        int          nframes;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int f0, p0, n, cs_falls, ld_falls, cs_low_seen;
        logic pf_cs, pf_ld;

        vecs[0] = '{16'h7FFF, 16'h0000, 1'b0, 24'h10FFFF, 24'h000000, 1};
        vecs[1] = '{16'h0000, 16'h8000, 1'b1, 24'h108000, 24'h110000, 2};
        vecs[2] = '{16'h8000, 16'hFFFF, 1'b0, 24'h100000, 24'h000000, 1};
        vecs[3] = '{16'h1234, 16'hFEDC, 1'b1, 24'h109234, 24'h117EDC, 2};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b1, 24'h107FFF, 24'h118001, 2};

        repeat (3) @(negedge clk);
        check("rst_main", {sclk, mosi, cs_n, ldac_n, busy, overrun}, 6'b001100);
        check("rst_fast", {f_sclk, f_mosi, f_cs_n, f_ldac_n, f_busy, f_overrun}, 6'b001100);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            ch_a = vecs[i].a; ch_b = vecs[i].b; dual_en = vecs[i].dual;
            exp_q.push_back(vecs[i].exp_a);
            if (vecs[i].dual) exp_q.push_back(vecs[i].exp_b);
            f0 = frames; p0 = pulses;
            kick("strobe_latency");
            enable = 1'b0;
            finish_seq("seq_done", 1000);
            repeat (2) @(negedge clk);
            check("frame_count", frames - f0, vecs[i].nframes);
            check("ldac_pulses", pulses - p0, 1);
            check("ldac_width", last_ldac, 2 * CLK_DIV);
            if (vecs[i].dual) check("cs_gap", last_gap, CS_GAP);
            check("queue_drained", exp_q.size(), 0);
        end

        // Inputs churn every cycle after capture; the frame must carry the captured value.
        ch_a = 16'h5A5A; dual_en = 1'b0;
        exp_q.push_back(24'h10DA5A);
        f0 = frames;
        kick("churn_latency");
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            ch_a = 16'($urandom); ch_b = 16'($urandom); dual_en = 1'($urandom);
            @(negedge clk);
            n++;
        end
        check("churn_done", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("churn_frames", frames - f0, 1);
        check("churn_queue", exp_q.size(), 0);

        // Overrun on the fast instance: dual sequence outlasts the 100-cycle sample period.
        dual_en = 1'b1; ch_a = 16'h1111; ch_b = 16'h2222;
        en_f = 1'b1; cs_falls = 0; ld_falls = 0; pf_cs = f_cs_n; pf_ld = f_ldac_n;
        for (int k = 1; k <= 760; k++) begin
            @(negedge clk);
            if (k <= 590 && !f_cs_n && pf_cs) cs_falls++;
            if (k <= 590 && !f_ldac_n && pf_ld) ld_falls++;
            pf_cs = f_cs_n; pf_ld = f_ldac_n;
            if (k == 199) check("ovr_before", f_overrun, 1'b0);
            if (k == 200) check("ovr_set", f_overrun, 1'b1);
            if (k == 590) begin
                check("ovr_drop_frames", cs_falls, 2);
                check("ovr_drop_ldac", ld_falls, 1);
            end
            if (k == 699) clr_f = 1'b1;
            if (k == 700) begin
                clr_f = 1'b0;
                check("ovr_set_wins", f_overrun, 1'b1);
            end
            if (k == 750) clr_f = 1'b1;
            if (k == 751) begin
                clr_f = 1'b0;
                check("ovr_clr", f_overrun, 1'b0);
            end
        end
        en_f = 1'b0;
        n = 0;
        while (f_busy !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("ovr_seq_done", f_busy, 1'b0);

        // Reset around bit 10 of frame A, then a clean dual sequence.
        ch_a = 16'h3C3C; ch_b = 16'hC3C3; dual_en = 1'b1;
        f0 = frames; p0 = pulses;
        kick("rst_mid_latency");
        n = 0;
        while (nbits < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_mid_outputs", {sclk, mosi, cs_n, ldac_n, busy, overrun}, 6'b001100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_no_frame", frames - f0, 0);
        exp_q.push_back(24'h10BC3C);
        exp_q.push_back(24'h1143C3);
        kick("post_rst_latency");
        enable = 1'b0;
        finish_seq("post_rst_done", 1000);
        repeat (2) @(negedge clk);
        check("post_rst_frames", frames - f0, 2);
        check("post_rst_ldac", pulses - p0, 1);
        check("post_rst_queue", exp_q.size(), 0);

        // Enable dropped mid frame A: A, B and LOAD finish, then the line stays quiet.
        ch_a = 16'h0F0F; ch_b = 16'hF0F0; dual_en = 1'b1;
        exp_q.push_back(24'h108F0F);
        exp_q.push_back(24'h1170F0);
        f0 = frames; p0 = pulses;
        kick("drop_latency");
        repeat (60) @(negedge clk);
        enable = 1'b0;
        finish_seq("drop_done", 1000);
        repeat (2) @(negedge clk);
        check("drop_frames", frames - f0, 2);
        check("drop_ldac", pulses - p0, 1);
        check("drop_gap", last_gap, CS_GAP);
        f0 = frames;
        cs_low_seen = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (!cs_n) cs_low_seen++;
        end
        check("drop_quiet_cs", cs_low_seen, 0);
        check("drop_quiet_frames", frames - f0, 0);
        check("drop_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
